// File: rtl/branch_predictor_bht_if.sv
// Fetch/resolve bus between the MIPS pipeline and the branch predictor.
//   pcF, predTakenF, predIdxF          : IF-stage prediction lookup
//   BranchD, stallD, shouldBranchD,
//   predTakenD, idxD, mispredictD      : ID-stage resolve/update and mispredict report
// master = pipeline side, slave = predictor side.
interface branch_predictor_bht_if #(
    parameter int IDX_W = 6
);
    logic [31:0]      pcF;
    logic             predTakenF;
    logic [IDX_W-1:0] predIdxF;
    logic             BranchD;
    logic             stallD;
    logic             shouldBranchD;
    logic             predTakenD;
    logic [IDX_W-1:0] idxD;
    logic             mispredictD;

    modport master (
        output pcF, BranchD, stallD, shouldBranchD, predTakenD, idxD,
        input  predTakenF, predIdxF, mispredictD
    );

    modport slave (
        input  pcF, BranchD, stallD, shouldBranchD, predTakenD, idxD,
        output predTakenF, predIdxF, mispredictD
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// Fetch-stage dynamic branch predictor: table of 2-bit saturating counters
// indexed by PC word bits, read combinationally at IF, trained by the resolved
// outcome from ID. Reports mispredicts for the hazard unit and keeps
// saturating branch/miss statistics.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   bus (slave)     : fetch lookup and ID resolve signals (see interface)
//   nBranch, nMiss  : resolved-branch and mispredict counts (saturating)
// Optional feature: define BP_GSHARE_EN to XOR a non-speculative global
// history register into the fetch index (gshare). Undefined = plain bimodal.
// The interface instance must be built with the same IDX_W as this module.
module branch_predictor_bht #(
    parameter int IDX_W  = 6,
    parameter int HIST_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predictor_bht_if.slave bus,
    output logic [CNT_W-1:0]      nBranch,
    output logic [CNT_W-1:0]      nMiss
);
    localparam int         ENTRIES = 1 << IDX_W;
    localparam logic [1:0] SN = 2'b00;
    localparam logic [1:0] WN = 2'b01;
    localparam logic [1:0] ST = 2'b11;

    logic [1:0]       tbl [ENTRIES];
    logic [IDX_W-1:0] base_idx;
    logic             upd;
    logic             unused_pc_bits;

    assign base_idx       = bus.pcF[IDX_W+1:2];
    assign unused_pc_bits = ^{bus.pcF[31:IDX_W+2], bus.pcF[1:0]};

`ifdef BP_GSHARE_EN
    // History only advances on resolved branches, so no repair is needed;
    // the update always targets the index carried down the pipe (idxD).
    logic [HIST_W-1:0] ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ghr <= '0;
        else if (upd)
            ghr <= HIST_W'({ghr, bus.shouldBranchD});
    end

    assign bus.predIdxF = base_idx ^ IDX_W'(ghr);
`else
    assign bus.predIdxF = base_idx;
`endif

    // No bypass: a same-cycle update of this entry is seen next cycle.
    assign bus.predTakenF  = tbl[bus.predIdxF][1];

    assign upd             = bus.BranchD & ~bus.stallD;
    assign bus.mispredictD = upd & (bus.predTakenD ^ bus.shouldBranchD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl[i] <= WN;
        end else if (upd) begin
            if (bus.shouldBranchD && tbl[bus.idxD] != ST)
                tbl[bus.idxD] <= tbl[bus.idxD] + 2'd1;
            else if (!bus.shouldBranchD && tbl[bus.idxD] != SN)
                tbl[bus.idxD] <= tbl[bus.idxD] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nBranch <= '0;
            nMiss   <= '0;
        end else if (upd) begin
            if (nBranch != '1)
                nBranch <= nBranch + 1'b1;
            if (bus.mispredictD && nMiss != '1)
                nMiss <= nMiss + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] nBranch;
    logic [15:0] nMiss;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    branch_predictor_bht_if #(.IDX_W(6)) bus ();

    branch_predictor_bht #(.IDX_W(6), .HIST_W(6), .CNT_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .nBranch (nBranch),
        .nMiss   (nMiss)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.BranchD       = 1'b0;
        bus.stallD        = 1'b0;
        bus.shouldBranchD = 1'b0;
        bus.predTakenD    = 1'b0;
        bus.idxD          = '0;
    endtask

    // One unstalled resolve; checks the combinational mispredict, then clocks it in.
    task automatic resolve(input logic [5:0] idx, input logic taken, input logic pred,
                           input logic exp_mis, input string tag);
        bus.BranchD       = 1'b1;
        bus.stallD        = 1'b0;
        bus.idxD          = idx;
        bus.shouldBranchD = taken;
        bus.predTakenD    = pred;
        #1;
        chk(tag, 32'(bus.mispredictD), 32'(exp_mis));
        @(posedge clk);
        #1;
        bus.BranchD = 1'b0;
    endtask

    task automatic pred_at(input logic [31:0] pc, input logic exp, input string tag);
        bus.pcF = pc;
        #1;
        chk(tag, 32'(bus.predTakenF), 32'(exp));
    endtask

    initial begin
        idle();
        bus.pcF = 32'h0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        chk("rst nBranch", 32'(nBranch), 32'd0);
        chk("rst nMiss", 32'(nMiss), 32'd0);
        pred_at(32'h0, 1'b0, "rst pred 0x0");
        pred_at(32'h40, 1'b0, "rst pred 0x40");
        pred_at(32'hFC, 1'b0, "rst pred 0xFC");

        // Training on idx 0x10: WN->WT->ST, then not-taken back to WT
        bus.pcF = 32'h40;
        resolve(6'h10, 1'b1, 1'b0, 1'b1, "train1 mis");
        pred_at(32'h40, 1'b1, "train1 pred WT");
        resolve(6'h10, 1'b1, 1'b1, 1'b0, "train2 mis");
        chk("train nBranch", 32'(nBranch), 32'd2);
        chk("train nMiss", 32'(nMiss), 32'd1);
        chk("train predIdxF", 32'(bus.predIdxF), 32'h10);
        resolve(6'h10, 1'b0, 1'b1, 1'b1, "train3 mis");
        pred_at(32'h40, 1'b1, "train3 pred WT");

        // Saturation at SN on idx 0x05; one taken step must land on WN (not WT)
        resolve(6'h05, 1'b0, 1'b0, 1'b0, "sat1 mis");
        resolve(6'h05, 1'b0, 1'b0, 1'b0, "sat2 mis");
        resolve(6'h05, 1'b0, 1'b0, 1'b0, "sat3 mis");
        pred_at(32'h14, 1'b0, "sat pred SN");
        resolve(6'h05, 1'b1, 1'b0, 1'b1, "sat4 mis");
        pred_at(32'h14, 1'b0, "sat pred WN");
        chk("sat nBranch", 32'(nBranch), 32'd7);
        chk("sat nMiss", 32'(nMiss), 32'd3);

        // Stall: three held cycles, then a single update when stallD drops
        bus.BranchD       = 1'b1;
        bus.stallD        = 1'b1;
        bus.idxD          = 6'h05;
        bus.shouldBranchD = 1'b1;
        bus.predTakenD    = 1'b0;
        bus.pcF           = 32'h14;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall mis", 32'(bus.mispredictD), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("stall nBranch", 32'(nBranch), 32'd7);
        chk("stall pred", 32'(bus.predTakenF), 32'd0);
        bus.stallD = 1'b0;
        #1;
        chk("unstall mis", 32'(bus.mispredictD), 32'd1);
        @(posedge clk);
        #1;
        bus.BranchD = 1'b0;
        chk("unstall nBranch", 32'(nBranch), 32'd8);
        chk("unstall nMiss", 32'(nMiss), 32'd4);
        pred_at(32'h14, 1'b1, "unstall pred WT");
        @(posedge clk);
        #1;
        chk("post-stall nBranch", 32'(nBranch), 32'd8);

        // Aliasing + same-cycle read/write of entry 0x10 (currently WT) via pc 0x140
        bus.pcF = 32'h140;
        #1;
        chk("alias predIdxF", 32'(bus.predIdxF), 32'h10);
        bus.BranchD       = 1'b1;
        bus.idxD          = 6'h10;
        bus.shouldBranchD = 1'b0;
        bus.predTakenD    = 1'b1;
        #1;
        chk("same-cycle old WT", 32'(bus.predTakenF), 32'd1);
        @(posedge clk);
        #1;
        chk("next-cycle new WN", 32'(bus.predTakenF), 32'd0);
        bus.shouldBranchD = 1'b1;
        bus.predTakenD    = 1'b0;
        #1;
        chk("same-cycle old WN", 32'(bus.predTakenF), 32'd0);
        @(posedge clk);
        #1;
        bus.BranchD = 1'b0;
        chk("next-cycle new WT", 32'(bus.predTakenF), 32'd1);
        pred_at(32'h40, 1'b1, "alias 0x40 shares entry");
        chk("alias nBranch", 32'(nBranch), 32'd10);
        chk("alias nMiss", 32'(nMiss), 32'd6);

        // Statistics saturation: force mispredicts well past 0xFFFF
        bus.BranchD       = 1'b1;
        bus.idxD          = 6'h20;
        bus.shouldBranchD = 1'b1;
        bus.predTakenD    = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat nMiss max", 32'(nMiss), 32'hFFFF);
        chk("sat nBranch max", 32'(nBranch), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("sat nMiss hold", 32'(nMiss), 32'hFFFF);
        chk("sat nBranch hold", 32'(nBranch), 32'hFFFF);

        // Asynchronous reset mid-run, in the middle of an active update
        bus.pcF = 32'h80;
        #1;
        chk("pre-reset 0x80 ST", 32'(bus.predTakenF), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst nBranch", 32'(nBranch), 32'd0);
        chk("async rst nMiss", 32'(nMiss), 32'd0);
        chk("async rst mis comb", 32'(bus.mispredictD), 32'd1);
        pred_at(32'h0, 1'b0, "mid rst pred 0x0");
        pred_at(32'h40, 1'b0, "mid rst pred 0x40");
        pred_at(32'hFC, 1'b0, "mid rst pred 0xFC");
        pred_at(32'h80, 1'b0, "mid rst pred 0x80");
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            pred_at(32'(i) << 2, 1'b0, "rst sweep");
        // One taken step from reset must predict taken: entries reset to WN
        bus.pcF = 32'h80;
        resolve(6'h20, 1'b1, 1'b0, 1'b1, "rst WN mis");
        pred_at(32'h80, 1'b1, "rst entry WN->WT");

`ifdef BP_GSHARE_EN
        // Gshare indexing: history T,T,NT from reset gives ghr=000110
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        resolve(6'h30, 1'b1, 1'b0, 1'b1, "ghr1 mis");
        resolve(6'h30, 1'b1, 1'b1, 1'b0, "ghr2 mis");
        resolve(6'h30, 1'b0, 1'b1, 1'b1, "ghr3 mis");
        bus.pcF = 32'h40;
        #1;
        chk("gshare predIdxF", 32'(bus.predIdxF), 32'h16);
`else
        bus.pcF = 32'h40;
        #1;
        chk("bimodal predIdxF", 32'(bus.predIdxF), 32'h10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
